// File: rtl/dpram_rdout_streamer_pkg.sv
// Shared definitions for the DPRAM readout streamer: FSM encoding and
// the geometry of a DPRAM word as seen by the 16-bit output stream.
package dpram_rdout_streamer_pkg;

  localparam int L_WORDS_PER_DPRAM_WORD = 4;
  localparam int L_DPRAM_WORD_WIDTH     = 64;
  localparam int L_OUT_WIDTH            = L_DPRAM_WORD_WIDTH / L_WORDS_PER_DPRAM_WORD;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STREAM,
    ST_DONE,
    ST_WAIT
  } state_e;

endpackage

// File: rtl/dpram_rdout_streamer_fifo.sv
// Two-entry 64-bit prefetch FIFO between the DPRAM read port and the
// halfword serialiser. Pushes into a full FIFO and pops from an empty one are ignored.
module rdout_prefetch_fifo
  import dpram_rdout_streamer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  logic [L_DPRAM_WORD_WIDTH-1:0] push_data_i,
  input  logic                          pop_i,
  output logic [L_DPRAM_WORD_WIDTH-1:0] head_o,
  output logic [1:0]                    count_o
);

  logic [L_DPRAM_WORD_WIDTH-1:0] mem_q [2];
  logic                          wr_ptr_q;
  logic                          rd_ptr_q;
  logic [1:0]                    count_q;
  logic                          do_push;
  logic                          do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i && (count_q != 2'd0);

  // NOTE: the two storage entries are reset so the head (and hence the
  // stream data) reads as zero after reset instead of stale contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block referring to pre-edge values, regardless of statement order.
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/dpram_rdout_streamer.sv
// Streams one filled double_buffer half out of the DPRAM as 16-bit words
// on a valid/ready interface, then releases the half with a done pulse.
module dpram_rdout_streamer
  import dpram_rdout_streamer_pkg::*;
#(
  parameter int P_ADR_WIDTH = 9,
  parameter int P_LEN_WIDTH = 16,
  parameter int P_CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic                          rd_busy,
  input  logic [P_LEN_WIDTH-1:0]        dpram_len,
  output logic [P_ADR_WIDTH-1:0]        rd_addr,
  input  logic [L_DPRAM_WORD_WIDTH-1:0] rd_dout,
  output logic                          done,
  output logic [L_OUT_WIDTH-1:0]        out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          len_err,
  output logic [P_CNT_WIDTH-1:0]        n_bufs_read
);

  localparam int L_MAX_LEN = L_WORDS_PER_DPRAM_WORD << P_ADR_WIDTH;
  // One extra bit so the issued-word count can reach 2^P_ADR_WIDTH.
  localparam int L_NA_W    = P_ADR_WIDTH + 1;

  state_e                        state_q, state_d;
  logic [P_LEN_WIDTH-1:0]        remaining_q, remaining_d;
  logic [L_NA_W-1:0]             n_dwords_q, n_dwords_d;
  logic [L_NA_W-1:0]             next_addr_q, next_addr_d;
  logic [P_ADR_WIDTH-1:0]        rd_addr_q, rd_addr_d;
  logic [1:0]                    in_flight_q, in_flight_d;
  logic [1:0]                    hw_q, hw_d;
  logic                          len_err_q, len_err_d;
  logic [P_CNT_WIDTH-1:0]        n_bufs_q, n_bufs_d;

  logic [1:0]                    fifo_count;
  logic [L_DPRAM_WORD_WIDTH-1:0] fifo_head;
  logic                          clamp;
  logic [P_LEN_WIDTH-1:0]        len_clamped;
  logic                          issue;
  logic                          push;
  logic                          pop;
  logic                          hs;
  logic                          last_word;

  assign clamp       = 32'(dpram_len) > 32'(L_MAX_LEN);
  assign len_clamped = clamp ? P_LEN_WIDTH'(L_MAX_LEN) : dpram_len;

  // A read is allowed only while the FIFO can absorb everything already requested.
  assign issue = (state_q == ST_STREAM)
              && ((3'(fifo_count) + 3'(in_flight_q)) < 3'd2)
              && (next_addr_q < n_dwords_q);
  assign push  = (in_flight_q != 2'd0);

  assign out_valid = (state_q == ST_STREAM) && (fifo_count != 2'd0);
  assign last_word = (remaining_q == P_LEN_WIDTH'(1));
  assign out_last  = out_valid && last_word;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && ((hw_q == 2'd3) || last_word);
  assign out_data  = out_valid ? fifo_head[{hw_q, 4'b0000} +: L_OUT_WIDTH] : '0;

  assign done        = (state_q == ST_DONE);
  assign rd_addr     = rd_addr_q;
  assign len_err     = len_err_q;
  assign n_bufs_read = n_bufs_q;

  rdout_prefetch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_data_i (rd_dout),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count)
  );

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    remaining_d = remaining_q;
    n_dwords_d  = n_dwords_q;
    next_addr_d = next_addr_q;
    rd_addr_d   = rd_addr_q;
    hw_d        = hw_q;
    len_err_d   = len_err_q;
    n_bufs_d    = n_bufs_q;
    in_flight_d = in_flight_q + 2'(issue) - 2'(push);

    unique case (state_q)
      ST_IDLE: begin
        if (en && rd_busy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        remaining_d = len_clamped;
        n_dwords_d  = L_NA_W'((32'(len_clamped) + 32'd3) >> 2);
        next_addr_d = '0;
        rd_addr_d   = '0;
        hw_d        = 2'd0;
        if (clamp) len_err_d = 1'b1;
        state_d = (len_clamped == '0) ? ST_DONE : ST_STREAM;
      end
      ST_STREAM: begin
        if (issue) begin
          next_addr_d = next_addr_q + L_NA_W'(1);
          // rd_addr parks on the last valid address instead of running past it.
          if ((next_addr_q + L_NA_W'(1)) < n_dwords_q) begin
            rd_addr_d = P_ADR_WIDTH'(next_addr_q + L_NA_W'(1));
          end
        end
        if (hs) begin
          remaining_d = remaining_q - P_LEN_WIDTH'(1);
          hw_d        = hw_q + 2'd1;
          if (last_word) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        n_bufs_d = n_bufs_q + P_CNT_WIDTH'(1);
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        // Holding here until rd_busy drops stops a second release of the same half.
        if (!rd_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      n_dwords_q  <= '0;
      next_addr_q <= '0;
      rd_addr_q   <= '0;
      in_flight_q <= 2'd0;
      hw_q        <= 2'd0;
      len_err_q   <= 1'b0;
      n_bufs_q    <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      n_dwords_q  <= n_dwords_d;
      next_addr_q <= next_addr_d;
      rd_addr_q   <= rd_addr_d;
      in_flight_q <= in_flight_d;
      hw_q        <= hw_d;
      len_err_q   <= len_err_d;
      n_bufs_q    <= n_bufs_d;
    end
  end

endmodule

// File: doc/dpram_rdout_streamer.md
# dpram_rdout_streamer

Read-side consumer of the readout `double_buffer`. When a filled half is handed over (`rd_busy`), it fetches the 64-bit DPRAM words, serialises them into 16-bit words on a valid/ready stream toward the host readout interface, and pulses `done` once the last word is accepted so the half is released back to `wvb_reader`. It replaces ad-hoc bench/readout logic with a backpressure-tolerant, prefetching streamer.

## Interface
Parameters:
- `P_ADR_WIDTH`, 9: DPRAM read address width; the maximum transfer is 4·2^P_ADR_WIDTH words.
- `P_LEN_WIDTH`, 16: width of the `dpram_len` word count.
- `P_CNT_WIDTH`, 16: width of the `n_bufs_read` counter.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  streamer enable. Sampled only in IDLE.
- `rd_busy`  in  1  double_buffer has a filled half ready for reading.
- `dpram_len`  in  P_LEN_WIDTH  transfer length in 16-bit words. Stable while `rd_busy` is high.
- `rd_addr`  out  P_ADR_WIDTH  DPRAM read address.
- `rd_dout`  in  64  DPRAM data, valid exactly 1 cycle after `rd_addr`.
- `done`  out  1  single-cycle release pulse to the double_buffer.
- `out_data`  out  16  stream word.
- `out_valid`  out  1  stream valid.
- `out_ready`  in  1  stream ready.
- `out_last`  out  1  marks the final word of a buffer.
- `len_err`  out  1  sticky flag: `dpram_len` exceeded the maximum. Cleared only by reset.
- `n_bufs_read`  out  P_CNT_WIDTH  count of completed buffers. Wraps.

## Operation
- Word order:
  - `rd_dout[15:0]` is sent first, then `[31:16]`, `[47:32]`, `[63:48]`.
  - Addresses ascend from 0.
- States:
  - IDLE → LOAD when `en && rd_busy`.
  - LOAD: latch `len = min(dpram_len, 4·2^P_ADR_WIDTH)`. Set `len_err` if clamping occurred. Go to DONE if `len == 0`, otherwise go to STREAM.
  - STREAM: issue reads and emit words. Go to DONE when the word with `out_last` is accepted.
  - DONE: pulse `done` for one cycle, increment `n_bufs_read`, then go to WAIT.
  - WAIT: remain until `rd_busy` deasserts, or reasserts after at least 1 low cycle, then return to IDLE. This prevents double-release of the same half.
- Prefetch:
  - A 2-entry FIFO of 64-bit words, plus a 2-bit in-flight counter.
  - A read is issued when `(fifo_count + in_flight) < 2` and `next_addr ≤ last_addr`, where `last_addr = ceil(len/4) - 1`.
- Partial last word: when `len % 4 = r ≠ 0`, only the first r halfwords of the final DPRAM word are emitted.
- Remaining-words counter:
  - Width P_LEN_WIDTH.
  - Decrements on each `out_valid && out_ready`.
  - `out_last = out_valid && (remaining == 1)`.
- Stream rule: `out_data` and `out_last` hold steady while `out_valid && !out_ready`.
- `en` deassertion mid-buffer has no effect; the current buffer completes.

## Timing
- Reset values:
  - State IDLE.
  - `rd_addr` = 0.
  - `done` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0.
  - `len_err` = 0, `n_bufs_read` = 0.
  - FIFO empty, in-flight counter 0.
- Latency from `rd_busy` high (cycle 0), with `out_ready` held high:
  - LOAD at cycle 1.
  - First `rd_addr` issued at cycle 2.
  - Data in the FIFO at cycle 3.
  - First `out_valid` at cycle 4.
- Throughput: one word per cycle sustained, with no bubbles at 64-bit word boundaries.
- `done` asserts on the cycle after the last handshake. With `len == 0`, `done` asserts at cycle 2.
- Simultaneous `rd_busy` fall and the last handshake: the transfer still completes and `done` still pulses.
- Reset mid-transfer: all state is cleared immediately and no `done` is issued. The double_buffer is reset in the same domain.

## Structure
- Shared package holds:
  - the state encoding;
  - `L_WORDS_PER_DPRAM_WORD = 4`;
  - `L_DPRAM_WORD_WIDTH = 64`.
- Natural sub-module: `rdout_prefetch_fifo`, a 2-deep, 64-bit synchronous FIFO with count output and async active-low reset.
- The serialiser, counters and FSM stay in the top level.

## Test plan
- `len=8`, `out_ready` held at 1:
  - words 0..7 appear at cycles 4..11, equal to the DPRAM halfwords in order;
  - `out_last` only with word 7;
  - `done` at cycle 12;
  - `n_bufs_read` = 1.
- `len=6`: exactly 6 words (the upper 2 halfwords of address 1 are dropped), `out_last` on the 6th, then a single `done`.
- `len=0`: no `out_valid`, `done` at cycle 2, `n_bufs_read` increments.
- `len=16` with `out_ready` toggling pseudo-randomly:
  - output sequence identical to the `ready=1` run;
  - `out_data` stable during stalls;
  - `rd_addr` never exceeds 3.
- `len=3000`: exactly 2048 words output, `len_err` = 1 and stays set across later buffers.
- Reset in the middle of a `len=64` transfer: all outputs return to their reset values, no `done` pulse; after reset, a fresh `len=4` buffer streams correctly.
